fmul_pipe: RTL and testbench

- Parametrised, pipelined FP multiplier with two exponent modes.
  - MUL: plain product x1·x2.
  - DIV: scaled product for the Newton-Raphson divide path. Exponent is e1 − e2 + BIAS − 1.
- Sits between the reciprocal-seed logic and fdiv/fmul consumers. Format is generic (EW/MW).
- Valid/ready handshake with full-pipeline stall, pass-through tag, explicit zero-input handling.

---
 rtl/fmul_pipe.sv | 127 ++++++++++++
 tb/tb_fmul_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - pipelined FP multiplier with MUL and reciprocal-divide (DIV) exponent modes.
// Optional round-to-nearest-even on the mantissa when FMUL_PIPE_RNE_EN is defined (truncation otherwise).
module fmul_pipe #(
  parameter int EW      = 8,
  parameter int MW      = 23,
  parameter int LATENCY = 3,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int W  = 1 + EW + MW;
  localparam int PW = 2 * MW + 2;
  localparam logic signed [EW+1:0] BIAS = {3'b000, {(EW-1){1'b1}}};
  localparam logic signed [EW+1:0] ONE  = {{(EW+1){1'b0}}, 1'b1};
  localparam logic signed [EW+1:0] EMAX = {2'b00, {EW{1'b1}}};
  localparam logic signed [EW+1:0] ZERO = '0;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic          s1, s2, sy;
  logic [EW-1:0] e1, e2;
  logic [MW-1:0] m1, m2;
  assign {s1, e1, m1} = x1;
  assign {s2, e2, m2} = x2;
  assign sy = s1 ^ s2;

  logic signed [EW+1:0] e1x, e2x;
  assign e1x = {2'b00, e1};
  assign e2x = {2'b00, e2};

  logic [PW-1:0]        p;
  logic signed [EW+1:0] eyp, ey, ey_r;
  logic [MW-1:0]        frac, frac_r;
  logic [W-1:0]         y_c;
  logic                 ovf_c;
`ifdef FMUL_PIPE_RNE_EN
  logic guard, sticky, rnd, carry;
`else
  logic unused_lsbs;
  assign unused_lsbs = ^p[MW-1:0];
`endif

  always_comb begin
    eyp = in_mode ? (e1x - e2x + BIAS - ONE) : (e1x + e2x - BIAS);
    p   = PW'({1'b1, m1}) * PW'({1'b1, m2});
    // Product of two [1,2) significands lies in [1,4); top bit selects the normalising shift.
    if (p[PW-1]) begin
      ey   = eyp + ONE;
      frac = p[2*MW:MW+1];
    end else begin
      ey   = eyp;
      frac = p[2*MW-1:MW];
    end
`ifdef FMUL_PIPE_RNE_EN
    guard  = p[PW-1] ? p[MW]         : p[MW-1];
    sticky = p[PW-1] ? |p[MW-1:0]    : |p[MW-2:0];
    rnd    = guard & (sticky | frac[0]);
    {carry, frac_r} = {1'b0, frac} + (MW+1)'(rnd);
    ey_r   = carry ? ey + ONE : ey;
`else
    frac_r = frac;
    ey_r   = ey;
`endif
    ovf_c = 1'b0;
    y_c   = {sy, ey_r[EW-1:0], frac_r};
    if ((&e1) || (&e2)) begin
      ovf_c = 1'b1;
      y_c   = {sy, {EW{1'b1}}, {MW{1'b0}}};
    end else if ((e1 == '0) || (e2 == '0)) begin
      y_c   = {sy, {EW{1'b0}}, {MW{1'b0}}};
    end else if (ey_r >= EMAX) begin
      ovf_c = 1'b1;
      y_c   = {sy, {EW{1'b1}}, {MW{1'b0}}};
    end else if (ey_r <= ZERO) begin
      y_c   = {sy, {EW{1'b0}}, {MW{1'b0}}};
    end
  end

  // Result is formed at the input and carried through LATENCY registers; whole chain freezes on stall.
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] ovf_q;
  logic [W-1:0]       y_q   [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        y_q[i]   <= '0;
        tag_q[i] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      ovf_q[0] <= ovf_c;
      y_q[0]   <= y_c;
      tag_q[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
        y_q[i]   <= y_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign ovf       = ovf_q[LATENCY-1];
  assign y         = y_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - scoreboard bench for fmul_pipe with directed hand-computed vectors.
module tb_fmul_pipe;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready, ovf;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] x1, x2, y;

  logic [31:0] exp_y_in;
  logic        exp_ovf_in;

  typedef struct packed {
    logic [31:0] y;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int npushed = 0;
  int nout = 0;

  fmul_pipe #(.EW(8), .MW(23), .LATENCY(LAT), .TAG_W(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_tag(in_tag), .x1(x1), .x2(x2),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rstn && in_valid && in_ready) begin
      sb.push_back('{y: exp_y_in, ovf: exp_ovf_in, tag: in_tag});
      npushed++;
    end
  end

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got y=%0h tag=%0h expected none", y, out_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y", 64'(y), 64'(e.y));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("tag", 64'(out_tag), 64'(e.tag));
        nout++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic mode, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] ey, input logic eovf);
    int n;
    in_valid = 1'b1; in_mode = mode; x1 = a; x2 = b; in_tag = tag;
    exp_y_in = ey; exp_ovf_in = eovf;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (n >= 100) chk("send_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic measure(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  int lat;
  logic [31:0] hold_y;
  logic [3:0]  hold_tag;
  logic        hold_ovf;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_tag = '0; x1 = '0; x2 = '0;
    out_ready = 1'b1; exp_y_in = '0; exp_ovf_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_y", 64'(y), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_tag", 64'(out_tag), 64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // MUL 2*3 then 1*1 back-to-back; latency of the first op
    send(1'b0, 32'h40000000, 32'h40400000, 4'd1, 32'h40C00000, 1'b0);
    fork
      send(1'b0, 32'h3F800000, 32'h3F800000, 4'd2, 32'h3F800000, 1'b0);
      measure(lat);
    join
    chk("latency", 64'(lat), 64'(LAT));
    @(posedge clk); #1;
    chk("b2b_valid", 64'(out_valid), 64'(1));
    chk("b2b_tag", 64'(out_tag), 64'(2));
    wait_idle();

    // DIV mode, specials, sign and exponent boundaries
    send(1'b1, 32'h3F800000, 32'h3F800000, 4'd3, 32'h3F000000, 1'b0);
    send(1'b1, 32'h40800000, 32'h3F800000, 4'd4, 32'h40000000, 1'b0);
    send(1'b0, 32'h7F000000, 32'h40000000, 4'd5, 32'h7F800000, 1'b1);
    send(1'b0, 32'h80800000, 32'h00800000, 4'd6, 32'h80000000, 1'b0);
    send(1'b0, 32'h00000000, 32'h40000000, 4'd7, 32'h00000000, 1'b0);
    send(1'b0, 32'h7F800000, 32'h00000000, 4'd8, 32'h7F800000, 1'b1);
    send(1'b0, 32'hC0000000, 32'h40400000, 4'd9, 32'hC0C00000, 1'b0);
    send(1'b0, 32'h7F000000, 32'h3F800000, 4'd10, 32'h7F000000, 1'b0);
    send(1'b0, 32'h00800000, 32'h3F800000, 4'd11, 32'h00800000, 1'b0);
    send(1'b1, 32'h3F800000, 32'h7F000000, 4'd12, 32'h00000000, 1'b0);
    wait_idle();

    // Backpressure: 5-cycle stall once tag 0 is presented
    fork
      begin
        send(1'b0, 32'h40000000, 32'h40400000, 4'd0, 32'h40C00000, 1'b0);
        send(1'b0, 32'h3F800000, 32'h3F800000, 4'd1, 32'h3F800000, 1'b0);
        send(1'b1, 32'h3F800000, 32'h3F800000, 4'd2, 32'h3F000000, 1'b0);
        send(1'b1, 32'h40800000, 32'h3F800000, 4'd3, 32'h40000000, 1'b0);
        send(1'b0, 32'h7F000000, 32'h40000000, 4'd4, 32'h7F800000, 1'b1);
        send(1'b0, 32'h80800000, 32'h00800000, 4'd5, 32'h80000000, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        chk("stall_tag0_seen", 64'(out_tag), 64'(0));
        out_ready = 1'b0;
        hold_y = y; hold_tag = out_tag; hold_ovf = ovf;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'(0));
          chk("stall_y_hold", 64'(y), 64'(hold_y));
          chk("stall_tag_hold", 64'(out_tag), 64'(hold_tag));
          chk("stall_ovf_hold", 64'(ovf), 64'(hold_ovf));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(1'b0, 32'h40000000, 32'h40400000, 4'd13, 32'h40C00000, 1'b0);
    send(1'b0, 32'h3F800000, 32'h3F800000, 4'd14, 32'h3F800000, 1'b0);
    measure(lat);
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("reset_drops_valid", 64'(out_valid), 64'(0));
    chk("reset_clears_y", 64'(y), 64'(0));
    npushed -= sb.size();
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    send(1'b0, 32'h40000000, 32'h40400000, 4'd15, 32'h40C00000, 1'b0);
    measure(lat);
    chk("post_reset_latency", 64'(lat), 64'(LAT));
    wait_idle();

    // Rounding-sensitive vectors
`ifdef FMUL_PIPE_RNE_EN
    send(1'b0, 32'h3FC00001, 32'h3FC00000, 4'd1, 32'h40100001, 1'b0);
`else
    send(1'b0, 32'h3FC00001, 32'h3FC00000, 4'd1, 32'h40100000, 1'b0);
`endif
    send(1'b0, 32'h3FFFFFFF, 32'h3F800001, 4'd2, 32'h40000000, 1'b0);
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    chk("out_count", 64'(nout), 64'(npushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
